// File: rtl/controle_multiciclo.sv
// Multi-cycle control unit for the calculator processor: accepts one instruction per
// valid/ready handshake, then sequences the ULA or data memory and strobes a register write.
module controle_multiciclo #(
   parameter  int INSTR_W = 32,
   parameter  int REG_W   = 2,
   parameter  int TIMEOUT = 16,
   localparam int IMM_W   = INSTR_W - 3 - 2*REG_W
) (
   input  logic               _clock,
   input  logic               _reset,
   input  logic               _instr_valid,
   output logic               _instr_ready,
   input  logic [INSTR_W-1:0] _instrucao,
   output logic [3:0]         _ula_op,
   output logic               _ula_start,
   input  logic               _ula_done,
   output logic [1:0]         _mem_control,
   output logic               _mem_enable,
   input  logic               _mem_ready,
   output logic [REG_W-1:0]   _reg_dest,
   output logic               _reg_write,
   output logic [IMM_W-1:0]   _imediato,
   output logic               _busy,
   output logic [1:0]         _erro
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DECODE    = 3'd1,
      WAIT_ULA  = 3'd2,
      WAIT_MEM  = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_DIV = 3'b010,
      OP_MUL = 3'b011,
      OP_CLR = 3'b100,
      OP_ILL = 3'b101,
      OP_RD  = 3'b110,
      OP_WR  = 3'b111
   } opcode_t;

   localparam logic [1:0] ERRO_NONE    = 2'b00;
   localparam logic [1:0] ERRO_ILEGAL  = 2'b01;
   localparam logic [1:0] ERRO_TIMEOUT = 2'b10;

   // Counter is just wide enough to hold TIMEOUT and saturates at all-ones.
   localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   function automatic logic [3:0] ula_code(input opcode_t op);
      case (op)
         OP_ADD:  ula_code = 4'b1000;
         OP_SUB:  ula_code = 4'b0100;
         OP_DIV:  ula_code = 4'b0001;
         OP_MUL:  ula_code = 4'b0010;
         default: ula_code = 4'b0000;
      endcase
   endfunction

   state_t             state, state_n;
   logic [INSTR_W-1:0] ir, ir_n;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_n;

   logic               instr_ready_n;
   logic [3:0]         ula_op_n;
   logic               ula_start_n;
   logic [1:0]         mem_control_n;
   logic               mem_enable_n;
   logic [REG_W-1:0]   reg_dest_n;
   logic               reg_write_n;
   logic [IMM_W-1:0]   imediato_n;
   logic               busy_n;
   logic [1:0]         erro_n;

   opcode_t opcode;
   assign opcode = opcode_t'(ir[INSTR_W-1 -: 3]);

   logic timeout_hit;
   assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

   always_comb begin
      // NOTE: every next-value signal is given a default before the case so no latch is inferred.
      state_n       = state;
      ir_n          = ir;
      wait_cnt_n    = wait_cnt;
      instr_ready_n = _instr_ready;
      ula_op_n      = _ula_op;
      ula_start_n   = 1'b0;
      mem_control_n = _mem_control;
      mem_enable_n  = _mem_enable;
      reg_dest_n    = _reg_dest;
      reg_write_n   = 1'b0;
      imediato_n    = _imediato;
      erro_n        = _erro;

      case (state)
         IDLE: begin
            instr_ready_n = 1'b1;
            if (_instr_valid && _instr_ready) begin
               ir_n          = _instrucao;
               instr_ready_n = 1'b0;
               erro_n        = ERRO_NONE;
               state_n       = DECODE;
            end
         end

         DECODE: begin
            imediato_n = ir[IMM_W-1:0];
            reg_dest_n = (opcode == OP_RD) ? ir[INSTR_W-4-REG_W -: REG_W]
                                           : ir[INSTR_W-4 -: REG_W];
            wait_cnt_n = '0;
            case (opcode)
               OP_ADD, OP_SUB, OP_DIV, OP_MUL: begin
                  ula_op_n    = ula_code(opcode);
                  ula_start_n = 1'b1;
                  state_n     = WAIT_ULA;
               end
               OP_CLR, OP_RD, OP_WR: begin
                  mem_control_n = ir[INSTR_W-2 -: 2];
                  mem_enable_n  = 1'b1;
                  ula_op_n      = 4'b0000;
                  state_n       = WAIT_MEM;
               end
               default: begin
                  erro_n        = ERRO_ILEGAL;
                  instr_ready_n = 1'b1;
                  state_n       = IDLE;
               end
            endcase
         end

         WAIT_ULA: begin
            // A response on the expiry edge still completes normally.
            if (_ula_done) begin
               reg_write_n = 1'b1;
               state_n     = WRITEBACK;
            end else if (timeout_hit) begin
               ula_op_n      = 4'b0000;
               mem_control_n = 2'b00;
               erro_n        = ERRO_TIMEOUT;
               instr_ready_n = 1'b1;
               state_n       = IDLE;
            end else if (wait_cnt != {CNT_W{1'b1}}) begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
         end

         WAIT_MEM: begin
            if (_mem_ready) begin
               mem_enable_n = 1'b0;
               if (opcode == OP_RD) begin
                  reg_write_n = 1'b1;
                  state_n     = WRITEBACK;
               end else begin
                  mem_control_n = 2'b00;
                  instr_ready_n = 1'b1;
                  state_n       = IDLE;
               end
            end else if (timeout_hit) begin
               mem_enable_n  = 1'b0;
               ula_op_n      = 4'b0000;
               mem_control_n = 2'b00;
               erro_n        = ERRO_TIMEOUT;
               instr_ready_n = 1'b1;
               state_n       = IDLE;
            end else if (wait_cnt != {CNT_W{1'b1}}) begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
         end

         WRITEBACK: begin
            ula_op_n      = 4'b0000;
            mem_control_n = 2'b00;
            instr_ready_n = 1'b1;
            state_n       = IDLE;
         end

         default: begin
            instr_ready_n = 1'b0;
            state_n       = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge _clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!_reset) begin
         state        <= IDLE;
         ir           <= '0;
         wait_cnt     <= '0;
         _instr_ready <= 1'b0;
         _ula_op      <= 4'b0000;
         _ula_start   <= 1'b0;
         _mem_control <= 2'b00;
         _mem_enable  <= 1'b0;
         _reg_dest    <= '0;
         _reg_write   <= 1'b0;
         _imediato    <= '0;
         _busy        <= 1'b0;
         _erro        <= ERRO_NONE;
      end else begin
         state        <= state_n;
         ir           <= ir_n;
         wait_cnt     <= wait_cnt_n;
         _instr_ready <= instr_ready_n;
         _ula_op      <= ula_op_n;
         _ula_start   <= ula_start_n;
         _mem_control <= mem_control_n;
         _mem_enable  <= mem_enable_n;
         _reg_dest    <= reg_dest_n;
         _reg_write   <= reg_write_n;
         _imediato    <= imediato_n;
         _busy        <= busy_n;
         _erro        <= erro_n;
      end
   end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Parametrised multi-cycle control unit for the calculator processor; successor to the single-cycle combinational decoder. Accepts one instruction per valid/ready handshake, then decodes it. Sequences a multi-cycle ULA (start/done) or the data memory (enable/ready) and issues a one-cycle register write strobe. Adds a wait timeout and an error report for illegal opcodes and hung handshakes.

Parameters:
INSTR_W, 32, instruction width; field layout is opcode [INSTR_W-1 -: 3], fonteA [INSTR_W-4 -: REG_W], dest [INSTR_W-4-REG_W -: REG_W], imediato [IMM_W-1:0]
REG_W, 2, register index width
IMM_W, INSTR_W-3-2*REG_W (25 at defaults), immediate width (derived, not overridable)
TIMEOUT, 16, max wait cycles for _ula_done/_mem_ready; 0 disables timeout

Ports:
_clock  in  1  single clock, rising edge
_reset  in  1  synchronous, active-low reset
_instr_valid  in  1  instruction offered
_instr_ready  out  1  unit idle, will accept
_instrucao  in  INSTR_W  instruction word
_ula_op  out  4  one-hot ULA op: 1000 add, 0100 sub, 0001 div, 0010 mul, 0000 none
_ula_start  out  1  one-cycle ULA start pulse
_ula_done  in  1  ULA result valid
_mem_control  out  2  memory op = opcode[1:0] (00 clear, 10 read, 11 write)
_mem_enable  out  1  memory request, held until _mem_ready
_mem_ready  in  1  memory completed request
_reg_dest  out  REG_W  destination register index
_reg_write  out  1  one-cycle register write strobe
_imediato  out  IMM_W  immediate field
_busy  out  1  state != IDLE
_erro  out  2  00 none, 01 illegal opcode, 10 timeout; sticky

Behaviour:
- All outputs registered. Reset (any edge with _reset=0) -> state IDLE, all outputs 0, wait counter 0, instruction register cleared. Any in-flight transaction is dropped and no _reg_write is issued. _instr_ready rises on first edge with _reset=1.
- States: IDLE, DECODE, WAIT_ULA, WAIT_MEM, WRITEBACK.
- IDLE: _instr_ready=1. On edge with _instr_valid & _instr_ready (T0): latch _instrucao, _instr_ready->0, _erro->00, go DECODE. _instr_valid is ignored whenever _instr_ready=0.
- DECODE (one cycle), at edge T1:
  - _imediato <= IR[IMM_W-1:0].
  - _reg_dest <= fonteA field; for read (110) it takes the dest field instead.
  - ALU ops (000,001,010,011): _ula_op set, _ula_start<=1, go WAIT_ULA.
  - Mem ops (100,110,111): _mem_control<=opcode[1:0], _mem_enable<=1, _ula_op=0000, go WAIT_MEM.
  - 101: _erro<=01, no start/enable, go IDLE.
- WAIT_ULA: _ula_start cleared at T2, so it is exactly one cycle wide. _ula_op held. _ula_done is sampled from T2 onward. On done -> WRITEBACK with _reg_write<=1.
- WAIT_MEM: _mem_enable held high. At the edge where _mem_ready=1, _mem_enable<=0; read -> WRITEBACK with _reg_write<=1; clear/write -> IDLE.
- WRITEBACK: _reg_write high exactly one cycle. Next edge -> IDLE: _reg_write<=0, _ula_op<=0000, _mem_control<=00, _instr_ready<=1. _reg_dest/_imediato hold until next DECODE.
- Timeout (TIMEOUT>0):
  - Counter cleared on entering a wait state, +1 per wait cycle without response.
  - At the edge where count reaches TIMEOUT with no response: deassert _mem_enable/_ula_op, _erro<=10, no _reg_write, go IDLE.
  - If the response and the expiry land on the same edge, completion wins.
  - Counter saturates and never wraps.
- _ula_done and _mem_ready are ignored outside their wait states.
- Minimum ALU latency, with _ula_done tied 1: accept T0, _ula_start high T1-T2, _reg_write high T2-T3, _instr_ready high again at T3.

Test Plan:
1. Reset: hold _reset=0 3 cycles with _instr_valid=1 and _instrucao=0x08000005 -> all outputs 0, nothing accepted. Release -> _instr_ready=1 after one edge.
2. Add 0x08000005, _ula_done tied 1 -> _ula_op=1000, _reg_dest=01, _imediato=5, _ula_start one cycle, _reg_write one cycle, _instr_ready back at T3, _erro=00.
3. Div 0x40000003 with _ula_done raised 8 cycles after start -> _ula_op=0001 held throughout, exactly one _reg_write, no timeout (8<16).
4. Read 0xD2000000, _mem_ready after 3 wait cycles -> _mem_control=10, _mem_enable high 3 cycles then 0, _reg_dest=01 (dest field), one _reg_write.
5. Write 0xE0000000, _mem_ready never asserted -> _mem_enable drops after 16 wait cycles, _erro=10, no _reg_write, _instr_ready=1. Accepting next instruction clears _erro to 00.
6. Illegal 0xA0000000 -> _erro=01, no _ula_start/_mem_enable/_reg_write. Separately, assert _reset=0 mid WAIT_ULA then pulse _ula_done -> no _reg_write, all outputs 0.
